// File: rtl/shifter_pkg.sv
// Shared types and defaults for the pipelined barrel shifter.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_level.sv
// One level of the log shifter: optionally shifts/rotates by the constant DIST.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_t        op_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  // Arithmetic fill stays correct across levels because the MSB survives every SRA step.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = data_i << DIST;
        OP_SRL:  data_o = data_i >> DIST;
        OP_SRA:  data_o = $signed(data_i) >>> DIST;
        OP_ROTR: data_o = (data_i >> DIST) | (data_i << (WIDTH - DIST));
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROTR shifter with valid/ready on both sides.
// Optional synchronous flush port enabled by defining PIPELINED_SHIFTER_FLUSH_EN.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SHAMT_W    = $clog2(WIDTH),
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
`ifdef PIPELINED_SHIFTER_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic                               flushReq;
  logic [PIPE_DEPTH-1:0]              valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][WIDTH-1:0]   data_q, data_d;
  logic [PIPE_DEPTH-1:0][SHAMT_W-1:0] shamt_q, shamt_d;
  logic [PIPE_DEPTH-1:0][1:0]         op_q, op_d;
  logic [PIPE_DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;

  logic [PIPE_DEPTH-1:0][WIDTH-1:0]   srcData, segOut;
  logic [PIPE_DEPTH-1:0][SHAMT_W-1:0] srcShamt;
  logic [PIPE_DEPTH-1:0][1:0]         srcOp;
  logic [PIPE_DEPTH-1:0][TAG_W-1:0]   srcTag;
  logic [SHAMT_W-1:0][WIDTH-1:0]      lvlOut;

  logic [PIPE_DEPTH:0]                canTake;
  logic [PIPE_DEPTH-1:0]              adv, load;

`ifdef PIPELINED_SHIFTER_FLUSH_EN
  assign flushReq = flush;
`else
  assign flushReq = 1'b0;
`endif

  // Segment 0 is fed from the input port, later segments from the previous segment register.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : gSrc
    if (k == 0) begin : gIn
      assign srcData[k]  = in_data;
      assign srcShamt[k] = in_shamt;
      assign srcOp[k]    = in_op;
      assign srcTag[k]   = in_tag;
    end else begin : gReg
      assign srcData[k]  = data_q[k-1];
      assign srcShamt[k] = shamt_q[k-1];
      assign srcOp[k]    = op_q[k-1];
      assign srcTag[k]   = tag_q[k-1];
    end
  end

  for (genvar i = 0; i < SHAMT_W; i++) begin : gLevel
    localparam int SEG   = i * PIPE_DEPTH / SHAMT_W;
    localparam bit FIRST = (i == 0) || (((i - 1) * PIPE_DEPTH / SHAMT_W) != SEG);
    localparam bit LAST  = (i == SHAMT_W - 1) || (((i + 1) * PIPE_DEPTH / SHAMT_W) != SEG);
    logic [WIDTH-1:0] lvlIn;

    if (FIRST) begin : gFirst
      assign lvlIn = srcData[SEG];
    end else begin : gChain
      assign lvlIn = lvlOut[i-1];
    end

    shift_level #(
      .WIDTH(WIDTH),
      .DIST (1 << i)
    ) uLevel (
      .data_i(lvlIn),
      .op_i  (shift_op_t'(srcOp[SEG])),
      .en_i  (srcShamt[SEG][i]),
      .data_o(lvlOut[i])
    );

    if (LAST) begin : gSegEnd
      assign segOut[SEG] = lvlOut[i];
    end
  end

  // Ready ripples back from the consumer; an empty segment can always take an entry.
  always_comb begin
    canTake             = '0;
    adv                 = '0;
    canTake[PIPE_DEPTH] = out_ready;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      adv[k]     = valid_q[k] && canTake[k+1];
      canTake[k] = !valid_q[k] || canTake[k+1];
    end
  end

  assign in_ready = canTake[0] && !flushReq;

  // A flush freezes every payload register so the last presented result stays on out_data.
  always_comb begin
    load    = '0;
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    load[0] = in_valid && in_ready;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      load[k] = adv[k-1] && !flushReq;
    end
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      valid_d[k] = flushReq ? 1'b0 : (load[k] || (valid_q[k] && !adv[k]));
      if (load[k]) begin
        data_d[k]  = segOut[k];
        shamt_d[k] = srcShamt[k];
        op_d[k]    = srcOp[k];
        tag_d[k]   = srcTag[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[PIPE_DEPTH-1];
  assign out_data  = data_q[PIPE_DEPTH-1];
  assign out_tag   = tag_q[PIPE_DEPTH-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=32, PIPE_DEPTH=2) with a scoreboard model.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int TAGW  = 5;

  logic            clk = 0;
  logic            reset = 0;
  logic            flush = 0;
  logic            in_valid = 0;
  logic            in_ready;
  logic [31:0]     in_data = '0;
  logic [SHW-1:0]  in_shamt = '0;
  logic [1:0]      in_op = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1;
  logic [31:0]     out_data;
  logic [TAGW-1:0] out_tag;
  logic            busy;

  int checks = 0;
  int failures = 0;

  logic [31:0]     expData[$];
  logic [TAGW-1:0] expTag[$];
  logic            stallPrev = 0;
  logic [31:0]     heldData;
  logic [TAGW-1:0] heldTag;

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .PIPE_DEPTH(2), .TAG_W(TAGW)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef PIPELINED_SHIFTER_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference behaviour straight from the operation definitions.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int s);
    logic [63:0] both;
    case (op)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return $signed(d) >>> s;
      default: begin
        both = {d, d} >> s;
        return both[31:0];
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Presents one operand and returns one time unit after the edge that accepted it.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d, input int sh, input logic [TAGW-1:0] tag);
    logic accepted;
    accepted = 0;
    in_op = op; in_data = d; in_shamt = SHW'(sh); in_tag = tag; in_valid = 1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic runOne(input logic [1:0] op, input logic [31:0] d, input int sh, input logic [TAGW-1:0] tag,
                        output logic [31:0] res);
    logic got;
    got = 0; res = 'x;
    applyStimulus(op, d, sh, tag);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; res = out_data; end
    end
    if (!got) checkOutput("out_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every accepted operand must emerge once, in order, and hold steady under backpressure.
  always @(negedge clk) begin
    if (!reset) begin
      expData.delete(); expTag.delete(); stallPrev = 0;
    end else begin
      if (stallPrev && !flush) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", out_data, heldData);
        checkOutput("hold_tag", 32'(out_tag), 32'(heldTag));
      end
      if (out_valid && out_ready) begin
        if (expData.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_data", out_data, expData.pop_front());
          checkOutput("sb_tag", 32'(out_tag), 32'(expTag.pop_front()));
        end
      end
      if (flush) begin
        expData.delete(); expTag.delete();
      end else if (in_valid && in_ready) begin
        expData.push_back(model(in_op, in_data, int'(in_shamt)));
        expTag.push_back(in_tag);
      end
      stallPrev = out_valid && !out_ready && !flush;
      heldData = out_data;
      heldTag = out_tag;
    end
  end

  initial begin
    logic [31:0] res;
    int idx, cyc;
    logic fired;

    // Reset state
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_out_data", out_data, 0);
    @(negedge clk); #2 reset = 1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(in_ready), 1);

    checkOutput("pin_model_sra", model(2, 32'h8000_0000, 4), 32'hF800_0000);
    checkOutput("pin_model_rotr", model(3, 32'h8000_0001, 31), 32'h0000_0003);

    // Latency and basic SLL
    applyStimulus(0, 32'h0000_0001, 31, 3);
    checkOutput("t1_not_yet", 32'(out_valid), 0);
    @(posedge clk); #1;
    checkOutput("t1_valid", 32'(out_valid), 1);
    checkOutput("t1_data", out_data, 32'h8000_0000);
    checkOutput("t1_tag", 32'(out_tag), 3);
    @(posedge clk); #1;

    runOne(2, 32'h8000_0000, 4, 4, res);  checkOutput("sra4", res, 32'hF800_0000);
    runOne(1, 32'h8000_0000, 4, 5, res);  checkOutput("srl4", res, 32'h0800_0000);
    for (int op = 0; op < 4; op++) begin
      runOne(2'(op), 32'hDEAD_BEEF, 0, 6, res);
      checkOutput($sformatf("sh0_op%0d", op), res, 32'hDEAD_BEEF);
    end
    runOne(3, 32'h0000_00F1, 4, 7, res);  checkOutput("rotr4", res, 32'h1000_000F);
    runOne(3, 32'h8000_0001, 31, 8, res); checkOutput("rotr31", res, 32'h0000_0003);
    runOne(0, 32'hFFFF_FFFF, 16, 9, res); checkOutput("sll16", res, 32'hFFFF_0000);

    // Backpressure: two entries fill the pipe, then drain in order without gaps
    out_ready = 0;
    in_op = 0; in_shamt = 0; in_valid = 1;
    in_data = 32'd1; in_tag = 1;
    @(negedge clk); checkOutput("bp_rdy1", 32'(in_ready), 1);
    @(posedge clk); #1; in_data = 32'd2; in_tag = 2;
    @(negedge clk); checkOutput("bp_rdy2", 32'(in_ready), 1);
    @(posedge clk); #1; in_data = 32'd3; in_tag = 3;
    @(negedge clk); checkOutput("bp_full", 32'(in_ready), 0);
    checkOutput("bp_head_tag", 32'(out_tag), 1);
    @(posedge clk); #1;
    @(negedge clk); checkOutput("bp_still_full", 32'(in_ready), 0);
    @(posedge clk); #1; out_ready = 1;
    @(negedge clk); checkOutput("bp_out1", 32'(out_tag), 1); checkOutput("bp_rdy3", 32'(in_ready), 1);
    @(posedge clk); #1; in_valid = 0;
    @(negedge clk); checkOutput("bp_v2", 32'(out_valid), 1); checkOutput("bp_out2", 32'(out_tag), 2);
    @(posedge clk); #1;
    @(negedge clk); checkOutput("bp_v3", 32'(out_valid), 1); checkOutput("bp_out3", 32'(out_tag), 3);
    @(posedge clk); #1;
    @(negedge clk); checkOutput("bp_empty", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Directed stream under a fixed out_ready pattern
    idx = 0; cyc = 0;
    while (idx < 40 && cyc < 400) begin
      in_op = 2'(idx % 4);
      in_data = 32'h9E37_79B1 * (idx + 1);
      in_shamt = SHW'((idx * 7) % 32);
      in_tag = TAGW'(idx);
      in_valid = 1;
      out_ready = (cyc % 3) != 1;
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1;
      if (fired) idx++;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    checkOutput("stream_sent", 32'(idx), 32'd40);
    for (int n = 0; n < 20 && busy; n++) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("stream_drained", 32'(expData.size()), 0);
    @(posedge clk); #1;

    // Reset with two entries in flight
    out_ready = 0;
    applyStimulus(1, 32'h1234_5678, 3, 7);
    applyStimulus(0, 32'h1234_5678, 3, 8);
    checkOutput("inflight_busy", 32'(busy), 1);
    #2 reset = 0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_tag", 32'(out_tag), 0);
    @(negedge clk); #2 reset = 1;
    out_ready = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_quiet%0d", n), 32'(out_valid), 0);
    end
    @(posedge clk); #1;

`ifdef PIPELINED_SHIFTER_FLUSH_EN
    out_ready = 0;
    applyStimulus(0, 32'h0000_0003, 2, 10);
    applyStimulus(0, 32'h0000_0005, 1, 11);
    flush = 1; in_valid = 1; in_data = 32'h55; in_shamt = 0; in_op = 0; in_tag = 12;
    @(negedge clk); checkOutput("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1; flush = 0; in_valid = 0;
    checkOutput("flush_busy", 32'(busy), 0);
    checkOutput("flush_valid", 32'(out_valid), 0);
    checkOutput("flush_data_held", out_data, 32'h0000_000C);
    out_ready = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput($sformatf("post_flush_quiet%0d", n), 32'(out_valid), 0);
    end
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
